// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct3 op codes and FSM state encoding for the iterative ALU
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SRL  = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_ops.sv
// rtl/alu_comb_ops.sv - single-cycle RV32I ops (ADD/SUB, SLT, SLTU, XOR, OR, AND)
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] y
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(operand_a) < $signed(operand_b);
  assign lt_unsigned = operand_a < operand_b;

  // Shift codes are handled by the iterative path in the parent; output 0 for them.
  always_comb begin
    y = '0;
    case (funct3)
      F3_ADD:  y = alt ? (operand_a - operand_b) : (operand_a + operand_b);
      F3_SLT:  y = {{(XLEN-1){1'b0}}, lt_signed};
      F3_SLTU: y = {{(XLEN-1){1'b0}}, lt_unsigned};
      F3_XOR:  y = operand_a ^ operand_b;
      F3_OR:   y = operand_a | operand_b;
      F3_AND:  y = operand_a & operand_b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - RV32I ALU with one-bit-per-cycle shifter and valid/ready handshake
module alu_iterative
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] count;
  logic               shift_left;
  logic               shift_arith;
  logic [XLEN-1:0]    comb_y;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               start_shift;
  logic               accept;

  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .funct3    (funct3),
    .alt       (alt),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .y         (comb_y)
  );

  assign shamt       = operand_b[SHAMT_W-1:0];
  assign is_shift    = (funct3 == F3_SLL) || (funct3 == F3_SRL);
  assign start_shift = is_shift && (shamt != '0);
  assign accept      = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = start_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (enable && (count == SHAMT_W'(1))) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (enable && out_ready) begin
          if (accept) state_next = start_shift ? ST_SHIFT : ST_DONE;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // reset_n gates in_ready so nothing looks acceptable while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  in_ready = reset_n && enable;
      ST_SHIFT: busy = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = reset_n && enable && out_ready;
      end
      default: ;
    endcase
  end

  // The result register doubles as the shift register while in SHIFT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result      <= '0;
      count       <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        result      <= operand_a;
        count       <= shamt;
        shift_left  <= (funct3 == F3_SLL);
        shift_arith <= alt && (funct3 == F3_SRL);
      end else begin
        result <= is_shift ? operand_a : comb_y;
        count  <= '0;
      end
    end else if ((state == ST_SHIFT) && enable) begin
      count  <= count - SHAMT_W'(1);
      result <= shift_left ? {result[XLEN-2:0], 1'b0}
                           : {shift_arith & result[XLEN-1], result[XLEN-1:1]};
    end
  end

endmodule
